// File: rtl/nes_mem_pkg.sv
// rtl/nes_mem_pkg.sv - shared types and constants for the mapper memory arbiter
// Contents:
//   MEM_AW      external memory address width
//   OPEN_BUS    data returned when the mapper blocks an access
//   arb_state_t arbiter FSM states
//   owner_t     requester identity (CPU / PPU)
package nes_mem_pkg;

    localparam int         MEM_AW   = 22;
    localparam logic [7:0] OPEN_BUS = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_PPU = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_req_slot.sv
// rtl/mem_req_slot.sv - single-entry pending request latch for one requester
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req, we, allow, addr, wdata   incoming request pulse and its fields
//   clear                         arbiter grant; empties the slot
//   pending                       slot holds an unserved request
//   slot_we, slot_allow,
//   slot_addr, slot_wdata         latched request fields
module mem_req_slot
    import nes_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic              allow,
    input  logic [MEM_AW-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic              clear,
    output logic              pending,
    output logic              slot_we,
    output logic              slot_allow,
    output logic [MEM_AW-1:0] slot_addr,
    output logic [7:0]        slot_wdata
);

    // A grant (clear) only ever happens while pending is set, so any req in
    // that same cycle would be ignored anyway; clear therefore takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= 1'b0;
            slot_we    <= 1'b0;
            slot_allow <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (req && !pending) begin
            pending    <= 1'b1;
            slot_we    <= we;
            slot_allow <= allow;
            slot_addr  <= addr;
            slot_wdata <= wdata;
        end
    end

endmodule

// File: rtl/mapper_mem_arbiter.sv
// rtl/mapper_mem_arbiter.sv - round-robin CPU/PPU arbiter for one shared external memory port
// Parameters:
//   MEM_LAT   cycles from the mem_rd strobe cycle to valid mem_rdata (1..15)
// Ports:
//   clk, reset                                    clock, synchronous active-high reset
//   prg_req/we/allow/addr/wdata, prg_ack/rdata    CPU read/write request and completion
//   chr_req/allow/addr, chr_ack/rdata             PPU read-only request and completion
//   mem_addr/rd/wr/wdata, mem_rdata               shared external memory port
module mapper_mem_arbiter
    import nes_mem_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prg_req,
    input  logic              prg_we,
    input  logic              prg_allow,
    input  logic [MEM_AW-1:0] prg_addr,
    input  logic [7:0]        prg_wdata,
    output logic              prg_ack,
    output logic [7:0]        prg_rdata,
    input  logic              chr_req,
    input  logic              chr_allow,
    input  logic [MEM_AW-1:0] chr_addr,
    output logic              chr_ack,
    output logic [7:0]        chr_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

    arb_state_t        state;
    arb_state_t        state_nxt;

    logic              prg_pending;
    logic              prg_slot_we;
    logic              prg_slot_allow;
    logic [MEM_AW-1:0] prg_slot_addr;
    logic [7:0]        prg_slot_wdata;
    logic              prg_clear;

    logic              chr_pending;
    logic              chr_slot_we;
    logic              chr_slot_allow;
    logic [MEM_AW-1:0] chr_slot_addr;
    logic [7:0]        chr_slot_wdata;
    logic              chr_clear;

    logic              grant_any;
    owner_t            grant_owner;
    logic              sel_we;
    logic              sel_allow;
    logic [MEM_AW-1:0] sel_addr;
    logic [7:0]        sel_wdata;

    owner_t            last_grant;
    owner_t            acc_owner;
    logic              acc_we;
    logic              acc_allow;
    logic [3:0]        cnt;
    logic              access_last;
    logic [7:0]        rd_value;

    mem_req_slot u_prg_slot (
        .clk        (clk),
        .reset      (reset),
        .req        (prg_req),
        .we         (prg_we),
        .allow      (prg_allow),
        .addr       (prg_addr),
        .wdata      (prg_wdata),
        .clear      (prg_clear),
        .pending    (prg_pending),
        .slot_we    (prg_slot_we),
        .slot_allow (prg_slot_allow),
        .slot_addr  (prg_slot_addr),
        .slot_wdata (prg_slot_wdata)
    );

    mem_req_slot u_chr_slot (
        .clk        (clk),
        .reset      (reset),
        .req        (chr_req),
        .we         (1'b0),
        .allow      (chr_allow),
        .addr       (chr_addr),
        .wdata      (8'h00),
        .clear      (chr_clear),
        .pending    (chr_pending),
        .slot_we    (chr_slot_we),
        .slot_allow (chr_slot_allow),
        .slot_addr  (chr_slot_addr),
        .slot_wdata (chr_slot_wdata)
    );

    // Round-robin: on a tie the PPU wins unless it was the last one granted.
    always_comb begin
        grant_any   = prg_pending || chr_pending;
        grant_owner = (chr_pending && (!prg_pending || last_grant == OWNER_CPU))
                      ? OWNER_PPU : OWNER_CPU;
        prg_clear   = (state == ST_IDLE) && grant_any && (grant_owner == OWNER_CPU);
        chr_clear   = (state == ST_IDLE) && grant_any && (grant_owner == OWNER_PPU);
        if (grant_owner == OWNER_PPU) begin
            sel_we    = chr_slot_we;
            sel_allow = chr_slot_allow;
            sel_addr  = chr_slot_addr;
            sel_wdata = chr_slot_wdata;
        end else begin
            sel_we    = prg_slot_we;
            sel_allow = prg_slot_allow;
            sel_addr  = prg_slot_addr;
            sel_wdata = prg_slot_wdata;
        end
    end

    // A blocked access spends a single ACCESS cycle without a strobe.
    assign access_last = !acc_allow || (cnt == 4'd0);
    assign rd_value    = acc_allow ? mem_rdata : OPEN_BUS;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant_any)   state_nxt = ST_ACCESS;
            ST_ACCESS: if (access_last) state_nxt = ST_DONE;
            ST_DONE:                    state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= OWNER_CPU;
            acc_owner  <= OWNER_CPU;
            acc_we     <= 1'b0;
            acc_allow  <= 1'b0;
            cnt        <= 4'd0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            prg_rdata  <= '0;
            chr_rdata  <= '0;
        end else begin
            // Strobes are single-cycle: they are only set on the grant edge.
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        acc_owner  <= grant_owner;
                        last_grant <= grant_owner;
                        acc_we     <= sel_we;
                        acc_allow  <= sel_allow;
                        cnt        <= sel_allow ? LAT_LOAD : 4'd0;
                        // Blocked accesses leave the memory port untouched.
                        if (sel_allow) begin
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                            mem_rd    <= !sel_we;
                            mem_wr    <= sel_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                    // Writes never touch the requester's read-data register.
                    if (access_last && !acc_we) begin
                        if (acc_owner == OWNER_PPU) begin
                            chr_rdata <= rd_value;
                        end else begin
                            prg_rdata <= rd_value;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign prg_ack = (state == ST_DONE) && (acc_owner == OWNER_CPU);
    assign chr_ack = (state == ST_DONE) && (acc_owner == OWNER_PPU);

endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// tb/tb_mapper_mem_arbiter.sv - self-checking bench for mapper_mem_arbiter against a transaction-level model
module tb_mapper_mem_arbiter;

    localparam int LAT  = 2;
    localparam int NONE = -100;

    logic        clk = 1'b0;
    logic        reset;
    logic        prg_req, prg_we, prg_allow;
    logic [21:0] prg_addr;
    logic [7:0]  prg_wdata;
    logic        prg_ack;
    logic [7:0]  prg_rdata;
    logic        chr_req, chr_allow;
    logic [21:0] chr_addr;
    logic        chr_ack;
    logic [7:0]  chr_rdata;
    logic [21:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    mapper_mem_arbiter #(.MEM_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .prg_req   (prg_req),
        .prg_we    (prg_we),
        .prg_allow (prg_allow),
        .prg_addr  (prg_addr),
        .prg_wdata (prg_wdata),
        .prg_ack   (prg_ack),
        .prg_rdata (prg_rdata),
        .chr_req   (chr_req),
        .chr_allow (chr_allow),
        .chr_addr  (chr_addr),
        .chr_ack   (chr_ack),
        .chr_rdata (chr_rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // stimulus for the next cycle
    logic        st_rst, st_preq, st_pwe, st_pallow, st_creq, st_callow;
    logic [21:0] st_paddr, st_caddr;
    logic [7:0]  st_pwd;

    // reference model: pending slots and the one transaction in flight
    bit          m_prg_pend, m_chr_pend, m_last_chr;
    logic        m_prg_we, m_prg_allow, m_chr_allow;
    logic [21:0] m_prg_addr, m_chr_addr;
    logic [7:0]  m_prg_wd;
    logic [7:0]  m_prg_rdata, m_chr_rdata;
    int          free_cyc, strobe_cyc, ack_cyc, post_reset_cyc;
    bit          ev_chr, ev_we, ev_allow;
    logic [21:0] ev_addr;
    logic [7:0]  ev_wd, ev_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_fn(input logic [21:0] a);
        if (a == 22'h012345) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
    endfunction

    task automatic clear_stim();
        st_rst = 1'b0; st_preq = 1'b0; st_pwe = 1'b0; st_pallow = 1'b1;
        st_creq = 1'b0; st_callow = 1'b1;
        st_paddr = '0; st_caddr = '0; st_pwd = '0;
    endtask

    task automatic model_reset();
        m_prg_pend = 0; m_chr_pend = 0; m_last_chr = 0;
        m_prg_rdata = '0; m_chr_rdata = '0;
        strobe_cyc = NONE; ack_cyc = NONE;
        free_cyc = cyc + 1; post_reset_cyc = cyc + 1;
    endtask

    task automatic run_cycle();
        bit gnt_chr, p_old, c_old;
        @(negedge clk);
        // compare outputs of the current cycle
        if (cyc == ack_cyc && !ev_we) begin
            if (ev_chr) m_chr_rdata = ev_data;
            else        m_prg_rdata = ev_data;
        end
        check_eq("mem_rd",    32'(mem_rd),    32'((cyc == strobe_cyc) && !ev_we));
        check_eq("mem_wr",    32'(mem_wr),    32'((cyc == strobe_cyc) && ev_we));
        check_eq("prg_ack",   32'(prg_ack),   32'((cyc == ack_cyc) && !ev_chr));
        check_eq("chr_ack",   32'(chr_ack),   32'((cyc == ack_cyc) && ev_chr));
        check_eq("prg_rdata", 32'(prg_rdata), 32'(m_prg_rdata));
        check_eq("chr_rdata", 32'(chr_rdata), 32'(m_chr_rdata));
        if (cyc >= strobe_cyc && cyc <= strobe_cyc + LAT) begin
            check_eq("mem_addr_hold", 32'(mem_addr), 32'(ev_addr));
            if (ev_we) check_eq("mem_wdata_hold", 32'(mem_wdata), 32'(ev_wd));
        end
        if (cyc == post_reset_cyc) begin
            check_eq("mem_addr_rst",  32'(mem_addr),  32'h0);
            check_eq("mem_wdata_rst", 32'(mem_wdata), 32'h0);
        end
        // drive this cycle's inputs
        reset = st_rst;
        prg_req = st_preq; prg_we = st_pwe; prg_allow = st_pallow;
        prg_addr = st_paddr; prg_wdata = st_pwd;
        chr_req = st_creq; chr_allow = st_callow; chr_addr = st_caddr;
        mem_rdata = (cyc == strobe_cyc + LAT && !ev_we) ? mem_fn(ev_addr) : 8'($urandom);
        // model the effect of the closing clock edge
        if (st_rst) begin
            model_reset();
        end else begin
            p_old = m_prg_pend;
            c_old = m_chr_pend;
            if (cyc >= free_cyc && (m_prg_pend || m_chr_pend)) begin
                gnt_chr = m_chr_pend && (!m_prg_pend || !m_last_chr);
                m_last_chr = gnt_chr;
                ev_chr = gnt_chr;
                if (gnt_chr) begin
                    ev_we = 0; ev_allow = m_chr_allow; ev_addr = m_chr_addr; ev_wd = '0;
                    m_chr_pend = 0;
                end else begin
                    ev_we = m_prg_we; ev_allow = m_prg_allow; ev_addr = m_prg_addr; ev_wd = m_prg_wd;
                    m_prg_pend = 0;
                end
                strobe_cyc = ev_allow ? cyc + 1 : NONE;
                ack_cyc    = cyc + (ev_allow ? LAT + 2 : 2);
                free_cyc   = ack_cyc + 1;
                ev_data    = ev_allow ? mem_fn(ev_addr) : 8'hFF;
            end
            if (st_preq && !p_old) begin
                m_prg_pend = 1; m_prg_we = st_pwe; m_prg_allow = st_pallow;
                m_prg_addr = st_paddr; m_prg_wd = st_pwd;
            end
            if (st_creq && !c_old) begin
                m_chr_pend = 1; m_chr_allow = st_callow; m_chr_addr = st_caddr;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            clear_stim();
            run_cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        prg_req = 0; prg_we = 0; prg_allow = 0; prg_addr = '0; prg_wdata = '0;
        chr_req = 0; chr_allow = 0; chr_addr = '0; mem_rdata = '0;
        ev_chr = 0; ev_we = 0; ev_allow = 0; ev_addr = '0; ev_wd = '0; ev_data = '0;
        m_prg_we = 0; m_prg_allow = 0; m_chr_allow = 0;
        m_prg_addr = '0; m_chr_addr = '0; m_prg_wd = '0;
        model_reset();
        repeat (2) @(posedge clk);
        clear_stim(); st_rst = 1; run_cycle();
        idle(2);

        // CPU read, mapper allows
        clear_stim(); st_preq = 1; st_paddr = 22'h012345; run_cycle();
        idle(7);

        // simultaneous pair, then a second pair in the first ack cycle
        clear_stim(); st_preq = 1; st_paddr = 22'h000100; st_creq = 1; st_caddr = 22'h200200; run_cycle();
        idle(4);
        clear_stim(); st_preq = 1; st_paddr = 22'h000111; st_creq = 1; st_caddr = 22'h200222; run_cycle();
        idle(16);

        // CPU write with allow, then blocked read and blocked write
        clear_stim(); st_preq = 1; st_pwe = 1; st_pwd = 8'h3C; st_paddr = 22'h001234; run_cycle();
        idle(7);
        clear_stim(); st_preq = 1; st_pallow = 0; st_paddr = 22'h004000; run_cycle();
        idle(5);
        clear_stim(); st_preq = 1; st_pallow = 0; st_pwe = 1; st_pwd = 8'h77; st_paddr = 22'h004001; run_cycle();
        idle(5);

        // reset in cycle 3 of a CHR access, then a fresh CHR read
        clear_stim(); st_creq = 1; st_caddr = 22'h300ABC; run_cycle();
        idle(2);
        clear_stim(); st_rst = 1; run_cycle();
        idle(1);
        clear_stim(); st_creq = 1; st_caddr = 22'h300ABD; run_cycle();
        idle(7);

        // second chr_req while the first is still pending
        clear_stim(); st_creq = 1; st_caddr = 22'h0000F0; run_cycle();
        clear_stim(); st_creq = 1; st_caddr = 22'h0000F1; run_cycle();
        idle(8);

        // request in the same cycle as reset is dropped
        clear_stim(); st_rst = 1; st_preq = 1; st_creq = 1; st_paddr = 22'h1; st_caddr = 22'h2; run_cycle();
        idle(6);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            clear_stim();
            st_rst    = ($urandom_range(0, 99) == 0);
            st_preq   = ($urandom_range(0, 3) == 0);
            st_pwe    = 1'($urandom);
            st_pallow = ($urandom_range(0, 4) != 0);
            st_paddr  = 22'($urandom);
            st_pwd    = 8'($urandom);
            st_creq   = ($urandom_range(0, 3) == 0);
            st_callow = ($urandom_range(0, 4) != 0);
            st_caddr  = 22'($urandom);
            run_cycle();
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
